// File: rtl/mem_access_pkg.sv
// Shared types and default sizing for the memory access controller.
package mem_access_pkg;
  localparam int ADDR_BITS_DEF  = 16;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int BE_WIDTH       = DATA_WIDTH_DEF / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } state_t;
endpackage

// File: rtl/mem_access_ctrl_be_merge.sv
// Byte-lane merge: enabled lanes from the new word, the rest from the old word.
// Purely combinational; no latency, no flow control.
module be_merge #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]   i_old,
  input  logic [DATA_WIDTH-1:0]   i_new,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  output logic [DATA_WIDTH-1:0]   o_merged
);
  always_comb begin
    o_merged = i_old;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (i_be[i]) o_merged[i*8 +: 8] = i_new[i*8 +: 8];
    end
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding CPU-to-SRAM access controller with read-modify-write for partial stores.
// Latency load 3 / full store 2 / partial store 4 / zero-be 1; req_ready only in IDLE, RESP holds until rsp_ready.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_BITS  = ADDR_BITS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_BITS-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_WriteEnable,
  output logic [ADDR_BITS/2-1:0]  mem_X_addr,
  output logic [ADDR_BITS/2-1:0]  mem_Y_addr,
  output logic [DATA_WIDTH-1:0]   mem_Data_in,
  input  logic [DATA_WIDTH-1:0]   mem_Data_out
);
  localparam int HALF = ADDR_BITS / 2;
  localparam int BE_W = DATA_WIDTH / 8;

  state_t                r_state;
  logic [ADDR_BITS-1:0]  r_addr;
  logic                  r_write;
  logic [BE_W-1:0]       r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_active;

  be_merge #(.DATA_WIDTH(DATA_WIDTH)) u_be_merge (
    .i_old    (mem_Data_out),
    .i_new    (r_wdata),
    .i_be     (r_be),
    .o_merged (w_merged)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_write <= req_write;
            r_be    <= req_be;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_err   <= 1'b0;
            if (!req_write) begin
              r_state <= ISSUE;
            end else if (req_be == '1) begin
              r_state <= WRITE;
            end else if (req_be == '0) begin
              // Nothing to store: reject without touching memory.
              r_err   <= 1'b1;
              r_state <= RESP;
            end else begin
              r_state <= ISSUE;
            end
          end
        end
        ISSUE:   r_state <= CAPTURE;
        CAPTURE: begin
          if (!r_write) begin
            r_rdata <= mem_Data_out;
            r_state <= RESP;
          end else begin
            r_wdata <= w_merged;
            r_state <= WRITE;
          end
        end
        WRITE:   r_state <= RESP;
        RESP:    if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_active        = (r_state == ISSUE) || (r_state == CAPTURE) || (r_state == WRITE);
  assign req_ready       = (r_state == IDLE) && Reset_n;
  assign rsp_valid       = (r_state == RESP);
  assign rsp_rdata       = r_rdata;
  assign rsp_err         = r_err;
  // Gated by Reset_n so a reset landing in WRITE can never commit the store.
  assign mem_WriteEnable = (r_state == WRITE) && Reset_n;
  assign mem_X_addr      = w_active ? r_addr[ADDR_BITS-1:HALF] : '0;
  assign mem_Y_addr      = w_active ? r_addr[HALF-1:0] : '0;
  assign mem_Data_in     = w_active ? r_wdata : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural memory, transaction-level reference model, random traffic.
module tb_mem_access_ctrl;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int BW = DW / 8;

  logic          Clock;
  logic          Reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_WriteEnable;
  logic [AW/2-1:0] mem_X_addr;
  logic [AW/2-1:0] mem_Y_addr;
  logic [DW-1:0] mem_Data_in;
  logic [DW-1:0] mem_Data_out;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem     [int];
  logic [DW-1:0] ref_mem [int];

  mem_access_ctrl #(.ADDR_BITS(AW), .DATA_WIDTH(DW)) dut (
    .Clock           (Clock),
    .Reset_n         (Reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_be          (req_be),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .mem_WriteEnable (mem_WriteEnable),
    .mem_X_addr      (mem_X_addr),
    .mem_Y_addr      (mem_Y_addr),
    .mem_Data_in     (mem_Data_in),
    .mem_Data_out    (mem_Data_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous-read SRAM: data for the address seen at an edge appears after that edge.
  always @(posedge Clock) begin
    int a;
    a = int'({mem_X_addr, mem_Y_addr});
    mem_Data_out <= mem.exists(a) ? mem[a] : '0;
    if (mem_WriteEnable) mem[a] = mem_Data_in;
  end

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] addr);
    int a;
    a = int'(addr);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input logic [BW-1:0] be, input int hold, input string tag,
                     output logic [DW-1:0] obs);
    logic [DW-1:0] mask, exp_new, exp_rd;
    bit            exp_err;
    int            exp_lat, exp_we, lat, we_cnt, n;
    mask = '0;
    for (int i = 0; i < BW; i++) if (be[i]) mask[i*8 +: 8] = 8'hFF;
    exp_new = (ref_rd(addr) & ~mask) | (wd & mask);
    exp_err = wr && (be == '0);
    exp_rd  = wr ? '0 : ref_rd(addr);
    exp_lat = !wr ? 3 : (be == 8'hFF) ? 2 : (be == 8'h00) ? 1 : 4;
    exp_we  = (wr && be != '0) ? 1 : 0;

    @(negedge Clock);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready: got %b want 1", tag, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge Clock);
    #1 req_valid = 1'b0;

    lat = 0; we_cnt = 0;
    while (lat < 20) begin
      @(negedge Clock);
      lat++;
      if (mem_WriteEnable) begin
        we_cnt++;
        checks++;
        if ({mem_X_addr, mem_Y_addr} !== addr || mem_Data_in !== exp_new) begin
          errors++;
          $display("FAIL %s write: got addr %h data %h want addr %h data %h",
                   tag, {mem_X_addr, mem_Y_addr}, mem_Data_in, addr, exp_new);
        end
      end
      if (rsp_valid) break;
    end
    checks++;
    if (lat != exp_lat || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d (valid=%b) want %0d", tag, lat, rsp_valid, exp_lat);
    end
    checks++;
    if (rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
      errors++;
      $display("FAIL %s response: got data %h err %b want data %h err %b",
               tag, rsp_rdata, rsp_err, exp_rd, exp_err);
    end
    checks++;
    if (we_cnt != exp_we) begin
      errors++;
      $display("FAIL %s we_count: got %0d want %0d", tag, we_cnt, exp_we);
    end
    checks++;
    if (mem_X_addr !== '0 || mem_Y_addr !== '0 || mem_Data_in !== '0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s resp_outputs: got x %h y %h din %h rdy %b want zeros",
               tag, mem_X_addr, mem_Y_addr, mem_Data_in, req_ready);
    end
    obs = rsp_rdata;

    for (int h = 0; h < hold; h++) begin
      @(negedge Clock);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== exp_err || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: got valid %b data %h err %b rdy %b want 1 %h %b 0",
                 tag, h, rsp_valid, rsp_rdata, rsp_err, req_ready, exp_rd, exp_err);
      end
    end
    rsp_ready = 1'b1;
    @(posedge Clock);
    #1 rsp_ready = 1'b0;
    @(negedge Clock);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_X_addr !== '0) begin
      errors++;
      $display("FAIL %s after_handshake: got valid %b rdy %b x %h want 0 1 00",
               tag, rsp_valid, req_ready, mem_X_addr);
    end
    if (wr && be != '0) ref_mem[int'(addr)] = exp_new;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clock);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 ||
        mem_WriteEnable !== 1'b0 || mem_X_addr !== '0 || mem_Y_addr !== '0 || mem_Data_in !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy %b vld %b data %h err %b we %b want all zero",
               req_ready, rsp_valid, rsp_rdata, rsp_err, mem_WriteEnable);
    end
    Reset_n = 1'b1;
    @(negedge Clock);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy %b vld %b want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_directed();
    logic [DW-1:0] obs;
    txn(1'b1, 16'h1234, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, "full_store", obs);
    txn(1'b0, 16'h1234, '0, '0, 0, "load_after_full", obs);
    checks++;
    if (obs !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("FAIL load_value: got %h want deadbeefcafef00d", obs);
    end
    txn(1'b1, 16'h1234, 64'h11223344_55667788, 8'h0F, 0, "partial_store", obs);
    txn(1'b0, 16'h1234, '0, '0, 0, "load_after_partial", obs);
    checks++;
    if (obs !== 64'hDEADBEEF_55667788) begin
      errors++;
      $display("FAIL partial_value: got %h want deadbeef55667788", obs);
    end
    txn(1'b1, 16'h1234, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 0, "zero_be_store", obs);
    txn(1'b0, 16'h1234, '0, '0, 5, "backpressure_load", obs);
    checks++;
    if (obs !== 64'hDEADBEEF_55667788) begin
      errors++;
      $display("FAIL zero_be_unchanged: got %h want deadbeef55667788", obs);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] obs, wd;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [AW-1:0] pool [5];
    pool[0] = 16'h1234; pool[1] = 16'h0000; pool[2] = 16'hFFFF;
    pool[3] = 16'h00FF; pool[4] = 16'hFF00;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) addr = AW'($urandom);
      else addr = pool[$urandom_range(0, 4)];
      case ($urandom_range(0, 3))
        0:       be = 8'h00;
        1:       be = 8'hFF;
        default: be = BW'($urandom);
      endcase
      wd = {$urandom, $urandom};
      txn(1'($urandom_range(0, 1)), addr, wd, be, $urandom_range(0, 3), "random", obs);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [DW-1:0] obs, prior;
    txn(1'b1, 16'hFFFF, 64'h0BAD_F00D_1234_5678, 8'hFF, 0, "prior_store", obs);
    prior = ref_rd(16'hFFFF);
    @(negedge Clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'hFFFF;
    req_wdata = 64'hAAAA_BBBB_CCCC_DDDD; req_be = 8'hFF;
    @(posedge Clock);
    #1 req_valid = 1'b0;
    @(negedge Clock);
    checks++;
    if (mem_WriteEnable !== 1'b1) begin
      errors++;
      $display("FAIL rst_write_state: got we %b want 1", mem_WriteEnable);
    end
    Reset_n = 1'b0;
    #1;
    checks++;
    if (mem_WriteEnable !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_we_gated: got we %b rdy %b want 0 0", mem_WriteEnable, req_ready);
    end
    @(negedge Clock);
    Reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      checks++;
      if (rsp_valid !== 1'b0 || mem_WriteEnable !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_after_release: got vld %b we %b rdy %b want 0 0 1",
                 rsp_valid, mem_WriteEnable, req_ready);
      end
    end
    txn(1'b0, 16'hFFFF, '0, '0, 0, "load_after_reset", obs);
    checks++;
    if (obs !== prior) begin
      errors++;
      $display("FAIL rst_prior_content: got %h want %h", obs, prior);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, word-address width, even.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, word width, multiple of 8.
REQ-003 SHALL have port Clock  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port Reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid  in  1  CPU request present.
REQ-006 SHALL have port req_ready  out  1  controller accepts request this cycle.
REQ-007 SHALL have port req_write  in  1  1=store, 0=load.
REQ-008 SHALL have port req_addr  in  ADDR_BITS  word address.
REQ-009 SHALL have port req_wdata  in  DATA_WIDTH  store data.
REQ-010 SHALL have port req_be  in  DATA_WIDTH/8  store byte enables; bit i covers byte i.
REQ-011 SHALL have port rsp_valid  out  1  response present.
REQ-012 SHALL have port rsp_ready  in  1  CPU accepts response.
REQ-013 SHALL have port rsp_rdata  out  DATA_WIDTH  load data; 0 for stores.
REQ-014 SHALL have port rsp_err  out  1  request rejected (store with req_be all-zero).
REQ-015 SHALL have port mem_WriteEnable  out  1  to data memory WriteEnable.
REQ-016 SHALL have port mem_X_addr  out  ADDR_BITS/2  row = req_addr[ADDR_BITS-1:ADDR_BITS/2].
REQ-017 SHALL have port mem_Y_addr  out  ADDR_BITS/2  column = req_addr[ADDR_BITS/2-1:0].
REQ-018 SHALL have port mem_Data_in  out  DATA_WIDTH  write word to memory.
REQ-019 SHALL have port mem_Data_out  in  DATA_WIDTH  memory read word, valid the cycle after the address is presented.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, CAPTURE, WRITE, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; acceptance = req_valid & req_ready at a rising edge; address, data, be, write latched then.
REQ-022 Accept transitions: load -> ISSUE; store, be all-ones -> WRITE; store, be partial -> ISSUE; store, be zero -> RESP with err=1, no memory access.
REQ-023 ISSUE SHALL drive latched X/Y with WE=0, go to CAPTURE unconditionally.
REQ-024 CAPTURE SHALL register mem_Data_out: load -> into rsp_rdata, go RESP; partial store -> merge (enabled bytes from wdata, others from mem_Data_out) into write register, go WRITE.
REQ-025 WRITE SHALL assert mem_WriteEnable for exactly one cycle with latched X/Y and write word, go RESP.
REQ-026 RESP SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready; on handshake go IDLE.
REQ-027 Latency from acceptance edge to rsp_valid: load 3 cycles, full store 2, partial store 4, zero-be store 1.
REQ-028 Back-to-back: next request accepted no earlier than the cycle after the response handshake; no overlap.
REQ-029 mem_X_addr/mem_Y_addr SHALL be 0 and mem_Data_in 0 in IDLE and RESP; latched values otherwise.
REQ-030 mem_WriteEnable SHALL = (state==WRITE) & Reset_n, decoded from registers only.
REQ-031 Load data containing X SHALL pass through unaltered; rsp_err stays 0.
REQ-032 Address wrap: all 2^ADDR_BITS addresses legal; no range error.

Reset
REQ-033 Reset_n low at an edge SHALL force IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, all latched registers 0.
REQ-034 Reset mid-operation SHALL drop the pending request with no response; no memory write while Reset_n is low, including in WRITE.
REQ-035 req_ready SHALL be 0 while Reset_n is low and 1 the first cycle after release.

Structure
REQ-036 Package mem_access_pkg SHALL hold the state enum, default ADDR_BITS/DATA_WIDTH constants, and BE_WIDTH = DATA_WIDTH/8.
REQ-037 A combinational sub-module be_merge (old word, new word, be -> merged word) SHALL implement the byte merge.

Verification
REQ-038 Full store addr 0x1234, wdata 0xDEADBEEF_CAFEF00D, be 0xFF -> WE one cycle at X=0x12, Y=0x34; rsp_valid 2 cycles after accept; err=0.
REQ-039 Load addr 0x1234 after REQ-038 -> rsp_rdata 0xDEADBEEF_CAFEF00D, 3 cycles after accept.
REQ-040 Partial store addr 0x1234, wdata 0x11223344_55667788, be 0x0F, then load -> 0xDEADBEEF_55667788; store response at 4 cycles.
REQ-041 Store with be 0x00 -> rsp_err=1 after 1 cycle, WE never asserted, subsequent load unchanged.
REQ-042 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready 0 throughout.
REQ-043 Reset_n low during WRITE of store to 0xFFFF -> no WE, no response, req_ready=1 after release, load 0xFFFF returns prior content.
